multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
- Multicycle RV32 control unit: the producer side of the ALU interface. Drives alucontrol, consumes zero.
- Sequences fetch, decode, execute, memory and writeback across cycles, and generates every datapath select and write enable.
- Sits between the instruction register and the shared-ALU multicycle datapath.

Parameters:
- ILLEGAL_TRAP, 0: unsupported opcode behaviour. 0 = return to FETCH; 1 = enter HALT until reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- op  in  7  instruction opcode, instr[6:0].
- funct3  in  3  instr[14:12].
- funct7b5  in  1  instr[30].
- zero  in  1  ALU zero flag.
- pcwrite  out  1  PC register enable.
- adrsrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
- memwrite  out  1  data memory write enable.
- irwrite  out  1  instruction register and oldPC enable.
- regwrite  out  1  register file write enable.
- resultsrc  out  2  result mux: 00 = ALUOut, 01 = memory data, 10 = ALU result.
- alusrca  out  2  srca mux: 00 = PC, 01 = oldPC, 10 = rs1.
- alusrcb  out  2  srcb mux: 00 = rs2, 01 = immediate, 10 = constant 4.
- immsrc  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- alucontrol  out  3  ALU operation: 000 ADD, 001 SUB, 010 AND, 011 OR, 101 SLT.
- illegal  out  1  high in DECODE when op is unsupported.
- halted  out  1  high in HALT.

Behaviour:
- Moore FSM; outputs are combinational from state and instruction fields. One exception: pcwrite = pcupdate | (branch & zero).
- Reset: state = FETCH, asynchronously.
  - While reset is high, pcwrite, irwrite, regwrite and memwrite are forced to 0.
  - All other outputs take their FETCH values.
  - illegal = 0, halted = 0.
- Outputs not listed for a state are 0.
- Supported opcodes:
  - lw = 0000011, sw = 0100011
  - R-type = 0110011, I-ALU = 0010011
  - beq = 1100011, jal = 1101111
- immsrc is decoded from op in every state: lw/I-ALU 00, sw 01, beq 10, jal 11, other 00.
- States, outputs and transitions:
  - FETCH: adrsrc=0, irwrite=1, alusrca=00, alusrcb=10, aluop=ADD, resultsrc=10, pcupdate=1. Next: DECODE.
  - DECODE: alusrca=01, alusrcb=01, aluop=ADD (precomputes branch target). Next by op: lw/sw → MEMADR, R → EXECUTER, I → EXECUTEI, jal → JAL, beq → BEQ. Any other op → illegal=1, then FETCH if ILLEGAL_TRAP=0, else HALT.
  - MEMADR: alusrca=10, alusrcb=01, aluop=ADD. Next: MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD: adrsrc=1, resultsrc=00. Next: MEMWB.
  - MEMWB: resultsrc=01, regwrite=1. Next: FETCH.
  - MEMWRITE: adrsrc=1, resultsrc=00, memwrite=1. Next: FETCH.
  - EXECUTER: alusrca=10, alusrcb=00, aluop=FUNCT. Next: ALUWB.
  - EXECUTEI: alusrca=10, alusrcb=01, aluop=FUNCT. Next: ALUWB.
  - ALUWB: resultsrc=00, regwrite=1. Next: FETCH.
  - BEQ: alusrca=10, alusrcb=00, aluop=SUB, resultsrc=00, branch=1. Next: FETCH.
  - JAL: alusrca=01, alusrcb=10, aluop=ADD, resultsrc=00, pcupdate=1. Next: ALUWB.
  - HALT: halted=1, all enables 0. Stays in HALT until reset.
- alucontrol decode:
  - aluop ADD → 000; aluop SUB → 001.
  - aluop FUNCT, by funct3:
    - 000 → 001 if (op[5] & funct7b5), else 000. So addi is always ADD.
    - 010 → 101
    - 110 → 011
    - 111 → 010
    - other → 000
- Latency in cycles: lw 5, sw 4, R 4, I 4, jal 4, beq 3, illegal 2 (trap off).
- beq: PC is written in BEQ only when zero=1. Otherwise PC holds the FETCH-incremented value.
- Reset mid-instruction: returns to FETCH immediately. No write enable is asserted in the reset cycle or after release until FETCH.

Test Plan:
- Reset mid-MEMWRITE, then release → state FETCH, memwrite=0 during reset. First post-reset cycle: irwrite=1, alusrcb=10, alucontrol=000.
- lw (op=0000011) → 5-cycle sequence FETCH/DECODE/MEMADR/MEMREAD/MEMWB. regwrite=1 only in cycle 5 with resultsrc=01; adrsrc=1 in cycle 4.
- R-type op=0110011, funct3=000, funct7b5=1 → alucontrol=001 in EXECUTER. Repeat with funct7b5=0 → 000. funct3=010 → 101, 110 → 011, 111 → 010.
- addi op=0010011, funct3=000, funct7b5=1 → alucontrol=000 and alusrcb=01 in EXECUTEI.
- beq with zero=1 → pcwrite=1 in BEQ, next state FETCH. With zero=0 → pcwrite=0. Both take 3 cycles.
- op=1111111 with ILLEGAL_TRAP=0 → illegal=1 in DECODE, then FETCH. With ILLEGAL_TRAP=1 → HALT, halted=1, all enables 0 for 10+ cycles until reset.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 control unit: sequences fetch/decode/execute/memory/writeback
// and drives every datapath select, write enable and the ALU operation.
module multicycle_ctrl #(
  parameter bit ILLEGAL_TRAP = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pcwrite,
  output logic       adrsrc,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic [1:0] resultsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] immsrc,
  output logic [2:0] alucontrol,
  output logic       illegal,
  output logic       halted
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_BEQ,
    S_JAL,
    S_HALT
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD,
    ALUOP_SUB,
    ALUOP_FUNCT
  } aluop_t;

  state_t state_q, state_d;
  aluop_t aluop;
  logic   op_known;
  logic   pcupdate;
  logic   branch;
  logic   irwrite_s;
  logic   regwrite_s;
  logic   memwrite_s;

  assign op_known = (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
                    (op == OP_I) || (op == OP_BEQ) || (op == OP_JAL);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default:      state_d = ILLEGAL_TRAP ? S_HALT : S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = S_FETCH;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    adrsrc     = 1'b0;
    resultsrc  = 2'b00;
    alusrca    = 2'b00;
    alusrcb    = 2'b00;
    aluop      = ALUOP_ADD;
    pcupdate   = 1'b0;
    branch     = 1'b0;
    irwrite_s  = 1'b0;
    regwrite_s = 1'b0;
    memwrite_s = 1'b0;
    illegal    = 1'b0;
    halted     = 1'b0;
    case (state_q)
      S_FETCH: begin
        irwrite_s = 1'b1;
        alusrcb   = 2'b10;
        resultsrc = 2'b10;
        pcupdate  = 1'b1;
      end
      S_DECODE: begin
        alusrca = 2'b01;
        alusrcb = 2'b01;
        illegal = ~op_known;
      end
      S_MEMADR: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
      end
      S_MEMREAD:  adrsrc = 1'b1;
      S_MEMWB: begin
        resultsrc  = 2'b01;
        regwrite_s = 1'b1;
      end
      S_MEMWRITE: begin
        adrsrc     = 1'b1;
        memwrite_s = 1'b1;
      end
      S_EXECUTER: begin
        alusrca = 2'b10;
        aluop   = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
        aluop   = ALUOP_FUNCT;
      end
      S_ALUWB:    regwrite_s = 1'b1;
      S_BEQ: begin
        alusrca = 2'b10;
        aluop   = ALUOP_SUB;
        branch  = 1'b1;
      end
      S_JAL: begin
        alusrca  = 2'b01;
        alusrcb  = 2'b10;
        pcupdate = 1'b1;
      end
      S_HALT:     halted = 1'b1;
      default: ;
    endcase
  end

  // Enables are gated by reset directly so nothing writes while reset is held.
  assign pcwrite  = ~reset & (pcupdate | (branch & zero));
  assign irwrite  = ~reset & irwrite_s;
  assign regwrite = ~reset & regwrite_s;
  assign memwrite = ~reset & memwrite_s;

  always_comb begin
    case (op)
      OP_SW:   immsrc = 2'b01;
      OP_BEQ:  immsrc = 2'b10;
      OP_JAL:  immsrc = 2'b11;
      default: immsrc = 2'b00;
    endcase
  end

  // op[5] separates R-type from I-ALU so that addi never becomes a subtract.
  always_comb begin
    alucontrol = 3'b000;
    case (aluop)
      ALUOP_SUB: alucontrol = 3'b001;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alucontrol = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  alucontrol = 3'b101;
          3'b110:  alucontrol = 3'b011;
          3'b111:  alucontrol = 3'b010;
          default: alucontrol = 3'b000;
        endcase
      end
      default: ;
    endcase
  end

endmodule
